// File: rtl/scan_misr_check_if.sv
// Bundles the scan-compaction control, stimulus and result signals of scan_misr_check.
// The master side drives the scan stream and control pulses; the slave side is the checker.
interface scan_misr_check_if #(
    parameter int CHAINS = 8,
    parameter int LENW   = 12
);
    logic              scan_en;
    logic [CHAINS-1:0] so;
    logic [CHAINS-1:0] so_mask;
    logic              start;
    logic              stop;
    logic [LENW-1:0]   len;
    logic [31:0]       sig_exp;
    logic [31:0]       misr;
    logic [15:0]       pat_cnt;
    logic              busy;
    logic              done;
    logic              pass;
    logic              len_err;

    modport master (
        output scan_en, so, so_mask, start, stop, len, sig_exp,
        input  misr, pat_cnt, busy, done, pass, len_err
    );

    modport slave (
        input  scan_en, so, so_mask, start, stop, len, sig_exp,
        output misr, pat_cnt, busy, done, pass, len_err
    );
endinterface

// File: rtl/scan_misr_check.sv
// Scan-out compactor: folds masked chain outputs into a 32-bit MISR over a test session,
// counts load/unload operations, flags wrong shift lengths and compares the final signature.
module scan_misr_check #(
    parameter int          CHAINS = 8,
    parameter logic [31:0] POLY   = 32'h04C11DB7,
    parameter int          LENW   = 12
) (
    input  logic              clk,
    input  logic              rstz,
    scan_misr_check_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [31:0]     misr_r;
    logic [31:0]     misr_nxt_s;
    logic [15:0]     pat_cnt_r;
    logic [15:0]     pat_cnt_nxt_s;
    logic [LENW-1:0] shift_cnt_r;
    logic [LENW-1:0] shift_cnt_nxt_s;
    logic [LENW-1:0] shift_inc_s;
    logic [LENW-1:0] count_s;
    logic            len_err_r;
    logic            len_err_nxt_s;
    logic            scan_en_d_r;
    logic            scan_en_d_nxt_s;
    logic            pass_r;
    logic            pass_nxt_s;
    logic            busy_r;
    logic            done_r;
    logic            load_end_s;

    // One Galois-form MISR step: multiply by x modulo the feedback polynomial, then inject data.
    function automatic logic [31:0] misr_step(input logic [31:0] cur, input logic [31:0] din);
        misr_step = {cur[30:0], 1'b0} ^ (cur[31] ? POLY : 32'h0000_0000) ^ din;
    endfunction

    assign shift_inc_s = (&shift_cnt_r) ? shift_cnt_r : shift_cnt_r + LENW'(1);

    // Session state transitions; start always takes priority over stop.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) state_nxt_s = ST_RUN;
                else           state_nxt_s = ST_IDLE;
            end
            ST_RUN: begin
                if (bus.start)     state_nxt_s = ST_RUN;
                else if (bus.stop) state_nxt_s = ST_DONE;
                else               state_nxt_s = ST_RUN;
            end
            ST_DONE: begin
                if (bus.start) state_nxt_s = ST_RUN;
                else           state_nxt_s = ST_DONE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Datapath next values: seeding, compaction, end-of-load bookkeeping and the final compare.
    always_comb begin
        misr_nxt_s      = misr_r;
        pat_cnt_nxt_s   = pat_cnt_r;
        shift_cnt_nxt_s = shift_cnt_r;
        len_err_nxt_s   = len_err_r;
        scan_en_d_nxt_s = 1'b0;
        pass_nxt_s      = pass_r;
        count_s         = shift_cnt_r;
        load_end_s      = 1'b0;
        if (bus.start) begin
            misr_nxt_s      = 32'hFFFF_FFFF;
            pat_cnt_nxt_s   = 16'h0000;
            shift_cnt_nxt_s = {LENW{1'b0}};
            len_err_nxt_s   = 1'b0;
            pass_nxt_s      = 1'b0;
        end else if (state_r == ST_RUN) begin
            scan_en_d_nxt_s = bus.scan_en;
            if (bus.scan_en) begin
                // masked chains are ANDed to 0 first, so an unknown there never reaches the MISR
                misr_nxt_s      = misr_step(misr_r, 32'(bus.so & bus.so_mask));
                count_s         = shift_inc_s;
                shift_cnt_nxt_s = shift_inc_s;
                load_end_s      = bus.stop;
            end else begin
                load_end_s      = scan_en_d_r;
            end
            if (load_end_s) begin
                pat_cnt_nxt_s   = (&pat_cnt_r) ? pat_cnt_r : pat_cnt_r + 16'd1;
                shift_cnt_nxt_s = {LENW{1'b0}};
                len_err_nxt_s   = len_err_r | (count_s != bus.len);
            end else begin
                len_err_nxt_s   = len_err_r;
            end
            if (bus.stop) pass_nxt_s = (misr_nxt_s == bus.sig_exp);
            else          pass_nxt_s = pass_r;
        end else begin
            pass_nxt_s = pass_r;
        end
    end

    // State register and registered state decodes.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == ST_RUN);
            done_r  <= (state_nxt_s == ST_DONE);
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            misr_r      <= 32'hFFFF_FFFF;
            pat_cnt_r   <= 16'h0000;
            shift_cnt_r <= {LENW{1'b0}};
            len_err_r   <= 1'b0;
            scan_en_d_r <= 1'b0;
            pass_r      <= 1'b0;
        end else begin
            misr_r      <= misr_nxt_s;
            pat_cnt_r   <= pat_cnt_nxt_s;
            shift_cnt_r <= shift_cnt_nxt_s;
            len_err_r   <= len_err_nxt_s;
            scan_en_d_r <= scan_en_d_nxt_s;
            pass_r      <= pass_nxt_s;
        end
    end

    assign bus.misr    = misr_r;
    assign bus.pat_cnt = pat_cnt_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.pass    = pass_r;
    assign bus.len_err = len_err_r;

endmodule

// File: tb/tb_scan_misr_check.sv
// Self-checking bench for scan_misr_check: a fixed vector table, directed multi-cycle
// sequences and a randomized run compared against a session-level reference model.
module tb_scan_misr_check;
    localparam int          CHAINS = 8;
    localparam int          LENW   = 12;
    localparam logic [31:0] POLY   = 32'h04C11DB7;

    logic clk = 1'b0;
    logic rstz;
    always #5 clk = ~clk;

    scan_misr_check_if #(.CHAINS(CHAINS), .LENW(LENW)) bus ();
    scan_misr_check #(.CHAINS(CHAINS), .POLY(POLY), .LENW(LENW)) dut (
        .clk(clk), .rstz(rstz), .bus(bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // reference model: session mode 0=idle 1=run 2=done
    int          m_mode;
    logic [31:0] m_sig;
    int          m_loads;
    int          m_shifts;
    bit          m_prev_shift;
    bit          m_err;
    bit          m_pass;

    typedef struct {
        logic        start;
        logic        stop;
        logic        scan_en;
        logic [7:0]  so;
        logic [7:0]  mask;
        logic [31:0] sig_exp;
        logic [31:0] e_misr;
        logic [15:0] e_pat;
        logic [3:0]  e_flags;
    } vec_t;
    vec_t tbl[10];

    function automatic logic [31:0] gf_step(input logic [31:0] s, input logic [31:0] d);
        logic [32:0] p;
        p = {s, 1'b0};
        if (p[32]) p = p ^ {1'b1, POLY};
        return p[31:0] ^ d;
    endfunction

    function automatic logic [31:0] flags();
        return 32'({bus.busy, bus.done, bus.pass, bus.len_err});
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_mode = 0; m_sig = 32'hFFFF_FFFF; m_loads = 0; m_shifts = 0;
        m_prev_shift = 1'b0; m_err = 1'b0; m_pass = 1'b0;
    endtask

    task automatic model_step();
        bit close;
        if (bus.start) begin
            m_mode = 1; m_sig = 32'hFFFF_FFFF; m_loads = 0; m_shifts = 0;
            m_prev_shift = 1'b0; m_err = 1'b0; m_pass = 1'b0;
        end else if (m_mode == 1) begin
            if (bus.scan_en) begin
                m_sig = gf_step(m_sig, 32'(bus.so & bus.so_mask));
                if (m_shifts < (1 << LENW) - 1) m_shifts++;
                close = bus.stop;
            end else begin
                close = m_prev_shift;
            end
            m_prev_shift = bus.scan_en;
            if (close) begin
                if (m_loads < 65535) m_loads++;
                if (m_shifts != int'(bus.len)) m_err = 1'b1;
                m_shifts = 0;
            end
            if (bus.stop) begin
                m_mode = 2;
                m_pass = (m_sig == bus.sig_exp);
            end
        end
    endtask

    task automatic model_compare(input string tag);
        check({tag, "_misr"}, bus.misr, m_sig);
        check({tag, "_pat"}, 32'(bus.pat_cnt), 32'(m_loads));
        check({tag, "_flags"}, flags(),
              32'({m_mode == 1, m_mode == 2, (m_mode == 2) && m_pass, m_err}));
    endtask

    task automatic drive(input logic st, input logic sp, input logic se,
                         input logic [7:0] so, input logic [7:0] mask);
        bus.start = st; bus.stop = sp; bus.scan_en = se; bus.so = so; bus.so_mask = mask;
    endtask

    task automatic tick(input bit cmp, input string tag);
        @(posedge clk);
        model_step();
        #1;
        if (cmp) model_compare(tag);
    endtask

    task automatic three_loads(input bit flip, input string tag);
        bus.len = 12'd4;
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'hFF); tick(1, tag);
        for (int l = 0; l < 3; l++) begin
            for (int s = 0; s < 4; s++) begin
                drive(1'b0, 1'b0, 1'b1, 8'($urandom), 8'hFF); tick(0, tag);
            end
            drive(1'b0, 1'b0, 1'b0, 8'h00, 8'hFF); tick(1, tag);
        end
        bus.sig_exp = m_sig ^ {31'd0, flip};
        drive(1'b0, 1'b1, 1'b0, 8'h00, 8'hFF); tick(1, tag);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'hFF);
        check({tag, "_done_pass"}, flags(), flip ? 32'h4 : 32'h6);
        check({tag, "_pat3"}, 32'(bus.pat_cnt), 32'd3);
    endtask

    initial begin
        logic [31:0] misr_a;
        logic [7:0]  data[10];

        rstz = 1'b0;
        bus.len = 12'd1; bus.sig_exp = 32'h0;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_misr", bus.misr, 32'hFFFF_FFFF);
        check("reset_pat", 32'(bus.pat_cnt), 32'd0);
        check("reset_flags", flags(), 32'h0);
        rstz = 1'b1;
        tick(1, "post_reset_idle");

        // vector table: single-shift signature, done/pass, start+stop, stop mid-load
        tbl[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'hFF, 32'h0,         32'hFFFFFFFF, 16'd0, 4'b1000};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 8'h01, 8'hFF, 32'h0,         32'hFB3EE248, 16'd0, 4'b1000};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 32'h0,         32'hFB3EE248, 16'd1, 4'b1000};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'hFF, 32'hFB3EE248, 32'hFB3EE248, 16'd1, 4'b0110};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 32'hFB3EE248, 32'hFB3EE248, 16'd1, 4'b0110};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF, 32'hFB3EE248, 32'hFB3EE248, 16'd1, 4'b0110};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 8'h00, 8'hFF, 32'h0,         32'hFFFFFFFF, 16'd0, 4'b1000};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'hFF, 32'h0,         32'hFB3EE249, 16'd0, 4'b1000};
        tbl[8] = '{1'b0, 1'b1, 1'b1, 8'h00, 8'hFF, 32'h0,         32'hF2BCD925, 16'd1, 4'b0101};
        tbl[9] = '{1'b0, 1'b0, 1'b1, 8'hFF, 8'hFF, 32'h0,         32'hF2BCD925, 16'd1, 4'b0101};
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].start, tbl[i].stop, tbl[i].scan_en, tbl[i].so, tbl[i].mask);
            bus.sig_exp = tbl[i].sig_exp;
            tick(0, "tbl");
            check($sformatf("tbl%0d_misr", i), bus.misr, tbl[i].e_misr);
            check($sformatf("tbl%0d_pat", i), 32'(bus.pat_cnt), 32'(tbl[i].e_pat));
            check($sformatf("tbl%0d_flags", i), flags(), 32'(tbl[i].e_flags));
        end

        three_loads(1'b0, "good_sig");
        three_loads(1'b1, "bad_sig");

        // one load of 5 shifts with len=4: sticky length error
        bus.len = 12'd4;
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'hFF); tick(1, "lenerr");
        for (int s = 0; s < 5; s++) begin
            drive(1'b0, 1'b0, 1'b1, 8'($urandom), 8'hFF); tick(1, "lenerr");
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'hFF); tick(1, "lenerr");
        check("lenerr_set", flags(), 32'h9);
        for (int s = 0; s < 4; s++) begin
            drive(1'b0, 1'b0, 1'b1, 8'($urandom), 8'hFF); tick(1, "lenerr");
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'hFF); tick(1, "lenerr");
        check("lenerr_sticky", flags(), 32'h9);
        check("lenerr_pat2", 32'(bus.pat_cnt), 32'd2);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'hFF); tick(1, "lenerr");
        check("lenerr_cleared", flags(), 32'h8);

        // masked chain 3 must not influence the signature
        for (int s = 0; s < 10; s++) data[s] = 8'($urandom);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'hF7); tick(1, "mask");
        for (int s = 0; s < 10; s++) begin
            drive(1'b0, 1'b0, 1'b1, data[s], 8'hF7); tick(1, "mask");
        end
        misr_a = bus.misr;
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'hF7); tick(1, "mask");
        for (int s = 0; s < 10; s++) begin
            drive(1'b0, 1'b0, 1'b1, data[s] ^ 8'h08, 8'hF7); tick(1, "mask");
        end
        check("mask_same_sig", bus.misr, misr_a);
        check("mask_known", 32'($isunknown(bus.misr)), 32'd0);
        drive(1'b1, 1'b1, 1'b0, 8'h00, 8'hFF); tick(1, "startstop");
        check("startstop_flags", flags(), 32'h8);
        check("startstop_seed", bus.misr, 32'hFFFF_FFFF);

        // asynchronous reset in the middle of a shift cycle
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'hFF); tick(1, "areset");
        drive(1'b0, 1'b0, 1'b1, 8'h5A, 8'hFF); tick(1, "areset");
        @(posedge clk);
        model_step();
        #3;
        rstz = 1'b0;
        #1;
        model_reset();
        check("areset_misr", bus.misr, 32'hFFFF_FFFF);
        check("areset_pat", 32'(bus.pat_cnt), 32'd0);
        check("areset_flags", flags(), 32'h0);
        @(posedge clk);
        #2;
        rstz = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 8'h00, 8'hFF); tick(1, "areset_stop");
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'hFF); tick(1, "areset_idle");
        check("areset_stop_ignored", flags(), 32'h0);

        // randomized sessions against the reference model
        for (int c = 0; c < 600; c++) begin
            bus.start   = ($urandom_range(0, 39) == 0);
            bus.stop    = ($urandom_range(0, 24) == 0);
            bus.scan_en = ($urandom_range(0, 3) != 0);
            bus.so      = 8'($urandom);
            bus.so_mask = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
            bus.sig_exp = ($urandom_range(0, 1) == 0) ? m_sig : 32'($urandom);
            if (bus.start) bus.len = 12'($urandom_range(0, 6));
            tick(1, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/scan_misr_check.md
SCAN_MISR_CHECK -- requirements
Module: scan_misr_check

Interface
REQ-001 Parameter CHAINS, default 8: number of scan-out chains compacted.
REQ-002 Parameter POLY, default 32'h04C11DB7: MISR feedback polynomial.
REQ-003 Parameter LENW, default 12: width of the shift-length and shift counters.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rstz  input  1  reset, asynchronous and active-low.
REQ-006 scan_en  input  1  high = shift cycle, low = capture/idle cycle.
REQ-007 so  input  CHAINS  scan-chain outputs, sampled on shift cycles.
REQ-008 so_mask  input  CHAINS  1 = chain compacted, 0 = chain forced to 0 (X-blocking).
REQ-009 start  input  1  one-cycle pulse: seed MISR and begin a session.
REQ-010 stop  input  1  one-cycle pulse: end session and compare.
REQ-011 len  input  LENW  required shift cycles per load/unload; static during a session.
REQ-012 sig_exp  input  32  expected final signature; static when stop is pulsed.
REQ-013 misr  output  32  current signature register.
REQ-014 pat_cnt  output  16  completed load/unload count, saturating at 16'hFFFF.
REQ-015 busy  output  1  high in state RUN.
REQ-016 done  output  1  high in state DONE.
REQ-017 pass  output  1  misr == sig_exp, valid only while done=1, else 0.
REQ-018 len_err  output  1  sticky: some load had a shift count != len.

Function
REQ-019 States: IDLE, RUN, DONE; encoded and registered, no other reachable state.
REQ-020 IDLE: start -> RUN; stop ignored.
REQ-021 RUN: stop -> DONE; start -> restart (re-seed, counters cleared, stays RUN).
REQ-022 DONE: start -> RUN; outputs held otherwise.
REQ-023 start and stop in the same cycle: start wins in every state.
REQ-024 On start: misr <= 32'hFFFFFFFF, pat_cnt <= 0, shift counter <= 0, len_err <= 0.
REQ-025 In RUN with scan_en=1: misr <= {misr[30:0],1'b0} ^ (misr[31] ? POLY : 0) ^ zero-extended (so & so_mask); shift counter increments, saturating at all-ones.
REQ-026 In RUN with scan_en=0: misr and shift counter hold.
REQ-027 End of load: the first RUN cycle with scan_en=0 after a cycle with scan_en=1 (registered scan_en delay) increments pat_cnt, clears the shift counter, and sets len_err if the counter != len.
REQ-028 A stop arriving while scan_en=1 closes the partial load: the len check and pat_cnt update of REQ-027 are applied in the same cycle as the move to DONE.
REQ-029 No compaction occurs outside RUN; the shift cycle coincident with the start pulse is not compacted.
REQ-030 pass is a registered compare: done and pass rise together one cycle after stop.
REQ-031 len = 0 means every load is flagged as len_err.
REQ-032 X on a masked chain has no effect on misr.

Reset
REQ-033 While rstz=0: state IDLE, misr = 32'hFFFFFFFF, pat_cnt = 0, shift counter = 0, busy = done = pass = len_err = 0.
REQ-034 Reset asserted mid-session aborts the session immediately; there is no recovery of partial signature.
REQ-035 After rstz deasserts, the block remains in IDLE until start.

Verification
REQ-036 start, one shift cycle with so=8'h01 and so_mask=8'hFF, then scan_en=0 -> misr=32'hFB3EE248, pat_cnt=1.
REQ-037 len=4, three loads of 4 shifts each, stop with sig_exp equal to a reference-model value -> done=1 and pass=1 one cycle after stop, len_err=0, pat_cnt=3.
REQ-038 Same as REQ-037 but with sig_exp bit 0 flipped -> pass=0, done=1.
REQ-039 len=4, one load of 5 shifts -> len_err=1 at end of load; len_err stays 1 until the next start or reset.
REQ-040 so[3]=X, so_mask=8'hF7, 10 shifts -> misr carries no X; start and stop in the same cycle -> re-seeded RUN, done=0.
REQ-041 rstz pulsed low mid-shift -> all outputs at REQ-033 values asynchronously; a subsequent stop is ignored.
